mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, word address of register 0; a hit is addr[31:5]==BASE_ADDR[31:5].
REQ-002 Parameter PRESCALE_W, default 16, width of the PRESCALE register.
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  bus access strobe; this is the processor's data-bus chip enable.
REQ-006 we  input  1  1 = write, 0 = read; qualified by ce.
REQ-007 addr  input  32  byte address; addr[1:0] ignored.
REQ-008 sel  input  4  byte enables; sel[i] enables data_i[8i+7:8i].
REQ-009 data_i  input  32  write data.
REQ-010 data_o  output  32  read data.
REQ-011 int_o  output  1  timer interrupt request, level; the SoC wires it to processor int_i[4].

Function
REQ-012 Register map, offsets from BASE_ADDR: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS, 0x10 PRESCALE; other offsets in the window read 0 and ignore writes.
REQ-013 CTRL bit0 EN (count enable), bit1 AR (auto-reload), bit2 IE (interrupt enable); bits 31:3 read 0.
REQ-014 Reads are combinational: data_o = selected register when ce=1, we=0 and hit; otherwise data_o = 32'h0.
REQ-015 Writes take effect at the edge where ce=1, we=1 and hit, per enabled byte lane only.
REQ-016 The prescaler counter pcnt (PRESCALE_W bits) increments while EN=1; when pcnt==PRESCALE it returns to 0 and asserts a one-cycle tick; PRESCALE=0 gives a tick every cycle.
REQ-017 While EN=0, pcnt holds 0 and no tick occurs.
REQ-018 On a tick with COUNT!=0: COUNT decrements by 1.
REQ-019 On a tick with COUNT==0: STATUS.bit0 (EXP) sets; if AR=1 then COUNT<=LOAD, else EN clears and COUNT holds 0.
REQ-020 A write to COUNT loads it directly and resets pcnt to 0; on the same edge it overrides a tick-driven update.
REQ-021 A write to STATUS clears EXP when data_i[0]=1 with sel[0]=1 (write-1-to-clear); if the same edge also sets EXP, the set wins.
REQ-022 A write to CTRL clearing EN on the same edge as an expiry leaves EN=0; the EXP set still occurs.
REQ-023 int_o = EXP & IE, a combinational function of registered state with no extra latency.
REQ-024 PRESCALE reads zero-extended to 32 bits; writes above PRESCALE_W are ignored.
REQ-025 Accesses with ce=0 have no effect and do not alter any register.

Reset
REQ-026 When rst=1 at an edge: CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0 and pcnt=0; data_o=0 and int_o=0 while rst=1.
REQ-027 Reset mid-count abandons the count, with no EXP and no interrupt generated.

Structure
REQ-028 Register offsets, CTRL bit positions and the timer base address constant are defined in defines.v; the bus width is RegBus.
REQ-029 Sub-module mmio_prescaler holds pcnt and generates tick; the register file and the decrement logic stay in mmio_timer.

Verification
REQ-030 Starting from reset, read all five offsets -> every read returns 0 and int_o=0.
REQ-031 Program PRESCALE=0, LOAD=3, COUNT=3, CTRL=3'b111 -> EXP sets and int_o=1 exactly 4 cycles after the CTRL write edge; COUNT then reloads to 3 and the sequence repeats every 4 cycles.
REQ-032 Program PRESCALE=2, COUNT=1, CTRL=3'b101 -> COUNT=0 after 3 cycles; EXP=1 and EN=0 after 6 cycles; COUNT stays at 0.
REQ-033 Write STATUS=32'h1 with sel=4'b0001 on the same edge as an expiry -> EXP stays 1; repeat on an idle edge -> EXP=0 and int_o=0.
REQ-034 Write 32'hAABBCCDD to LOAD with sel=4'b0101 over an initial value of 0 -> LOAD reads 32'h00BB00DD.
REQ-035 Assert rst for one cycle while COUNT=2 and EN=1 -> all registers read 0, and no int_o pulse occurs afterwards.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared constants and helpers for the memory-mapped down-counting timer.
// Word offsets, control bit positions and the byte-lane merge used on writes.
package mmio_timer_pkg;

  localparam int RegBus = 32;

  localparam logic [31:0] TIMER_BASE = 32'h1000_0000;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  function automatic logic [RegBus-1:0] lane_merge(
    input logic [RegBus-1:0] old_v,
    input logic [RegBus-1:0] wdata,
    input logic [3:0]        be
  );
    logic [RegBus-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Prescaler: free-running count from 0 to PRESCALE while enabled,
// emitting a one-cycle tick on the wrap.
module mmio_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] prescale_i,
  output logic         tick_o
);

  logic [W-1:0] pcnt_q, pcnt_d;

  // A COUNT write restarts the prescaler and swallows this cycle's tick.
  assign tick_o = en_i && !clr_i && (pcnt_q == prescale_i);

  always_comb begin
    pcnt_d = pcnt_q + W'(1);
    if (!en_i || clr_i || tick_o)
      pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with auto-reload, prescaler
// and a level interrupt (EXP & IE).
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = TIMER_BASE,
  parameter int          PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [3:0]        sel,
  input  logic [RegBus-1:0] data_i,
  output logic [RegBus-1:0] data_o,
  output logic              int_o
);

  logic [2:0]            ctrl_q, ctrl_d;
  logic [RegBus-1:0]     load_q, load_d;
  logic [RegBus-1:0]     count_q, count_d;
  logic                  exp_q, exp_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;

  logic              hit, wr, tick, expire;
  logic [2:0]        off;
  logic              wr_ctrl, wr_load, wr_count;
  logic              wr_status, wr_pre;
  logic [RegBus-1:0] wctrl, wload, wcount, wpre;
  logic [RegBus-1:0] rdata;
  logic              unused;

  assign hit = addr[31:5] == BASE_ADDR[31:5];
  assign off = addr[4:2];
  assign wr  = ce && we && hit;

  assign wr_ctrl   = wr && off == OFF_CTRL;
  assign wr_load   = wr && off == OFF_LOAD;
  assign wr_count  = wr && off == OFF_COUNT;
  assign wr_status = wr && off == OFF_STATUS;
  assign wr_pre    = wr && off == OFF_PRESCALE;

  assign wctrl  = lane_merge(RegBus'(ctrl_q), data_i, sel);
  assign wload  = lane_merge(load_q, data_i, sel);
  assign wcount = lane_merge(count_q, data_i, sel);
  assign wpre   = lane_merge(RegBus'(pre_q), data_i, sel);

  assign unused = ^{addr[1:0], wctrl, wpre};

  mmio_prescaler #(.W(PRESCALE_W)) u_pre (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ctrl_q[CTRL_EN]),
    .clr_i      (wr_count),
    .prescale_i (pre_q),
    .tick_o     (tick)
  );

  assign expire = tick && count_q == '0;

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    pre_d   = pre_q;
    if (tick)
      count_d = (count_q != '0) ? count_q - 1'b1
              : (ctrl_q[CTRL_AR] ? load_q : '0);
    unique case (1'b1)
      wr_ctrl:   ctrl_d  = wctrl[2:0];
      wr_load:   load_d  = wload;
      wr_count:  count_d = wcount;
      wr_status: if (sel[0] && data_i[STATUS_EXP]) exp_d = 1'b0;
      wr_pre:    pre_d   = PRESCALE_W'(wpre);
      default: ;
    endcase
    // Expiry beats a same-edge W1C and a same-edge EN write.
    if (expire) begin
      exp_d = 1'b1;
      if (!ctrl_q[CTRL_AR]) ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      pre_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata = RegBus'(ctrl_q);
      OFF_LOAD:     rdata = load_q;
      OFF_COUNT:    rdata = count_q;
      OFF_STATUS:   rdata = RegBus'(exp_q);
      OFF_PRESCALE: rdata = RegBus'(pre_q);
      default:      rdata = '0;
    endcase
  end

  assign data_o = (ce && !we && hit && !rst) ? rdata : '0;
  assign int_o  = !rst && exp_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench: directed timer scenarios plus random bus
// traffic against a cycle-level behavioural model.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst, ce, we;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;
  logic        int_o;

  always #5 clk = ~clk;

  mmio_timer dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (data_i),
    .data_o (data_o),
    .int_o  (int_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count;
  logic        m_exp;
  logic [15:0] m_pre, m_pcnt;
  logic [31:0] last_rd;

  function automatic logic [31:0] merge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic h,
                                         input logic [2:0] off);
    if (rst || !h) return 32'h0;
    case (off)
      3'd0: return {29'b0, m_ctrl};
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return {31'b0, m_exp};
      3'd4: return {16'b0, m_pre};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_ctrl = '0; m_load = '0; m_count = '0;
    m_exp = 1'b0; m_pre = '0; m_pcnt = '0;
  endtask

  task automatic m_step(input logic w, input logic [2:0] off,
                        input logic [3:0] s, input logic [31:0] d);
    logic en, ar, cw, tick, expire;
    logic [31:0] m;
    en     = m_ctrl[0];
    ar     = m_ctrl[1];
    cw     = w && off == 3'd2;
    tick   = en && m_pcnt == m_pre && !cw;
    expire = tick && m_count == 0;
    m_pcnt = (!en || cw || tick) ? 16'd0 : m_pcnt + 16'd1;
    if (tick)
      m_count = (m_count != 0) ? m_count - 1 : (ar ? m_load : 32'd0);
    if (w) begin
      case (off)
        3'd0: begin m = merge({29'b0, m_ctrl}, d, s); m_ctrl = m[2:0]; end
        3'd1: m_load = merge(m_load, d, s);
        3'd2: m_count = merge(m_count, d, s);
        3'd3: if (s[0] && d[0]) m_exp = 1'b0;
        3'd4: begin m = merge({16'b0, m_pre}, d, s); m_pre = m[15:0]; end
        default: ;
      endcase
    end
    if (expire) begin
      m_exp = 1'b1;
      if (!ar) m_ctrl[0] = 1'b0;
    end
  endtask

  // One bus cycle, entered and left just after a falling edge.
  task automatic cyc(input logic c, input logic w, input logic h,
                     input logic [2:0] off, input logic [3:0] s,
                     input logic [31:0] d, input string tag);
    ce     = c;
    we     = w;
    addr   = (h ? BASE : BASE + 32'h20) + {27'b0, off, 2'b00}
           + 32'($urandom_range(0, 3));
    sel    = s;
    data_i = d;
    #1;
    last_rd = data_o;
    if (c && !w) chk(tag, data_o, m_read(h, off));
    chk("int_o", {31'b0, int_o},
        {31'b0, !rst && m_exp && m_ctrl[2]});
    @(posedge clk);
    if (rst) m_reset();
    else     m_step(c && w && h, off, s, d);
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b1, off, 4'hF, d, "wr");
  endtask

  task automatic rd(input logic [2:0] off, input string tag);
    cyc(1'b1, 1'b0, 1'b1, off, 4'hF, 32'h0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 32'h0, "idle");
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0;
    addr = BASE; sel = 4'h0; data_i = 32'h0;
    m_reset();
    @(negedge clk);
    idle(2);
    rst = 1'b0;

    // Reset state
    for (int o = 0; o < 5; o++) begin
      rd(3'(o), "rst_rd");
      chk("rst_rd_zero", last_rd, 32'h0);
    end
    chk("rst_int", {31'b0, int_o}, 32'h0);

    // Byte-lane write
    cyc(1'b1, 1'b1, 1'b1, 3'd1, 4'b0101, 32'hAABB_CCDD, "wr");
    rd(3'd1, "load_rd");
    chk("load_lanes", last_rd, 32'h00BB_00DD);

    // Auto-reload period of 4 with PRESCALE=0
    wr(3'd4, 32'h0);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h7);
    idle(3);
    chk("ar_int_e3", {31'b0, int_o}, 32'h0);
    idle(1);
    chk("ar_int_e4", {31'b0, int_o}, 32'h1);
    rd(3'd2, "ar_cnt");
    chk("ar_reload", last_rd, 32'd3);
    wr(3'd3, 32'h1);
    idle(1);
    chk("ar_int_e7", {31'b0, int_o}, 32'h0);
    idle(1);
    chk("ar_int_e8", {31'b0, int_o}, 32'h1);

    // W1C on expiry edge loses; on idle edge clears
    wr(3'd3, 32'h1);
    idle(2);
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 4'b0001, 32'h1, "wr");
    rd(3'd3, "w1c_race");
    chk("w1c_race_exp", last_rd, 32'h1);
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 4'b0001, 32'h1, "wr");
    rd(3'd3, "w1c_idle");
    chk("w1c_idle_exp", last_rd, 32'h0);
    chk("w1c_idle_int", {31'b0, int_o}, 32'h0);
    wr(3'd0, 32'h0);

    // One-shot with PRESCALE=2
    wr(3'd4, 32'd2);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'h5);
    idle(3);
    rd(3'd2, "os_cnt");
    chk("os_cnt_e3", last_rd, 32'd0);
    idle(2);
    rd(3'd0, "os_ctrl");
    chk("os_en_clr", last_rd, 32'h4);
    rd(3'd3, "os_st");
    chk("os_exp", last_rd, 32'h1);
    rd(3'd2, "os_cnt2");
    chk("os_cnt_hold", last_rd, 32'd0);
    wr(3'd3, 32'h1);

    // Reset mid-count
    wr(3'd4, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd0, 32'h5);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int o = 0; o < 5; o++) begin
      rd(3'(o), "mid_rst_rd");
      chk("mid_rst_zero", last_rd, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("mid_rst_int", {31'b0, int_o}, 32'h0);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  o;
      logic [31:0] d;
      o = 3'($urandom_range(0, 7));
      d = $urandom;
      if (o == 3'd1 || o == 3'd2) d = 32'($urandom_range(0, 7));
      if (o == 3'd4) d = 32'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      cyc(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
          o, 4'($urandom), d, "rnd_rd");
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
